// File: rtl/hazard_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : hazard_scheduler
// Purpose  : Pipeline hazard and memory-wait scheduler for the 5-stage ARM
//            core. It detects RAW hazards between the ID sources and the
//            EXE/MEM destinations, and it runs the MEM-stage handshake with the
//            SRAM controller. All stage registers are frozen until an access
//            completes.
// Ports    : clk, rst (async, active-high)
//            forwardingEnabled                - relaxes hazard rule to load-use
//            src{1,2}Valid_id, src{1,2}_id    - ID-stage source operands
//            writeBackEnabled_{exe,mem}       - EXE/MEM write the register file
//            destination_{exe,mem}            - EXE/MEM destination registers
//            memRead_exe                      - EXE instruction is a load
//            memRead_mem, memWrite_mem        - MEM instruction is load/store
//            memReady                         - SRAM completion pulse
//            counterClear                     - sync clear of perf counters
//            memReq                           - request to SRAM controller
//            hazardStall                      - hold PC/IFID, bubble IDEXE
//            pipelineFreeze                   - hold all stage registers
//            stallCycles, freezeCycles        - saturating perf counters
// Config   : HAZARD_PERF_COUNTER_EN - builds the performance counters; when it
//            is undefined, both counter outputs are tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_scheduler #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             forwardingEnabled,
    input  logic             src1Valid_id,
    input  logic             src2Valid_id,
    input  logic [3:0]       src1_id,
    input  logic [3:0]       src2_id,
    input  logic             writeBackEnabled_exe,
    input  logic             writeBackEnabled_mem,
    input  logic [3:0]       destination_exe,
    input  logic [3:0]       destination_mem,
    input  logic             memRead_exe,
    input  logic             memRead_mem,
    input  logic             memWrite_mem,
    input  logic             memReady,
    input  logic             counterClear,
    output logic             memReq,
    output logic             hazardStall,
    output logic             pipelineFreeze,
    output logic [CNT_W-1:0] stallCycles,
    output logic [CNT_W-1:0] freezeCycles
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY    = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t state;
    logic   mem_req_q;

    // ------------------------------------------------------------------------
    // RAW hazard detection
    // ------------------------------------------------------------------------
    logic match_exe;
    logic match_mem;
    logic hazard;
    logic mem_op;

    assign match_exe = (src1Valid_id && (src1_id == destination_exe)) ||
                       (src2Valid_id && (src2_id == destination_exe));
    assign match_mem = (src1Valid_id && (src1_id == destination_mem)) ||
                       (src2Valid_id && (src2_id == destination_mem));

    // With forwarding only a load in EXE cannot be bypassed in time.
    assign hazard = forwardingEnabled ?
                    (memRead_exe && writeBackEnabled_exe && match_exe) :
                    ((writeBackEnabled_exe && match_exe) ||
                     (writeBackEnabled_mem && match_mem));

    assign mem_op = memRead_mem || memWrite_mem;

    // ------------------------------------------------------------------------
    // Memory handshake FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            mem_req_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (mem_op) begin
                        state     <= ST_BUSY;
                        mem_req_q <= 1'b1;
                    end
                end
                ST_BUSY: begin
                    if (memReady) begin
                        state     <= ST_RELEASE;
                        mem_req_q <= 1'b0;
                    end
                end
                ST_RELEASE: begin
                    // memOp still reflects the completed access; ignore it.
                    state     <= ST_IDLE;
                    mem_req_q <= 1'b0;
                end
                default: begin
                    state     <= ST_IDLE;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign memReq = mem_req_q;

    // In IDLE the freeze is taken the same cycle the access is seen. Reset
    // gates it so that a reset during an access releases the pipeline at once.
    assign pipelineFreeze = !rst &&
                            ((state == ST_BUSY) || ((state == ST_IDLE) && mem_op));

    // A frozen pipeline never takes a bubble.
    assign hazardStall = hazard && !pipelineFreeze;

    // ------------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------------
`ifdef HAZARD_PERF_COUNTER_EN
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] freeze_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt  <= '0;
            freeze_cnt <= '0;
        end else if (counterClear) begin
            stall_cnt  <= '0;
            freeze_cnt <= '0;
        end else begin
            if (hazardStall && (stall_cnt != {CNT_W{1'b1}}))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (pipelineFreeze && (freeze_cnt != {CNT_W{1'b1}}))
                freeze_cnt <= freeze_cnt + CNT_W'(1);
        end
    end

    assign stallCycles  = stall_cnt;
    assign freezeCycles = freeze_cnt;
`else
    logic unused_counter_clear;
    assign unused_counter_clear = counterClear;
    assign stallCycles  = '0;
    assign freezeCycles = '0;
`endif

endmodule
`default_nettype wire
